// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60 raster constants,
// the raster counter width, and the 12-bit RGB colour type with the
// common colours used by the renderers.
package vga_timing_pkg;

    localparam int CNT_W           = 10;

    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_VIS_START = 144;
    localparam int DEF_H_VIS_END   = 783;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_VIS_START = 35;
    localparam int DEF_V_VIS_END   = 514;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t RGB_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb_t RGB_RED   = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam rgb_t RGB_GREEN = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam rgb_t RGB_BLUE  = '{r: 4'h0, g: 4'h0, b: 4'hF};

    // Force black outside the visible window so renderers never drive
    // colour during blanking.
    function automatic rgb_t rgb_blank(input rgb_t colour, input logic bright);
        rgb_t result;
        if (bright) begin
            result = colour;
        end else begin
            result = RGB_BLACK;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_timing_gen_clk_div_en.sv
// Pixel-rate enable: divides clk by CLK_DIV and emits a registered
// one-clk strobe when the divider sits at its last count.
module clk_div_en
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             pix_en_r;

    // Free-running divider and strobe register; reset restarts the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r    <= {DIV_W{1'b0}};
            pix_en_r <= 1'b0;
        end else begin
            if (div_r == DIV_LAST) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            pix_en_r <= (div_r == DIV_LAST);
        end
    end

    assign pix_en = pix_en_r;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-rate enable, horizontal/vertical
// counters and registered sync/visible decodes that change on the same
// edge as the counters. Optional build macro FRAME_COUNT_EN adds a
// frame_start pulse and a 16-bit frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_VIS_START = DEF_H_VIS_START,
    parameter int H_VIS_END   = DEF_H_VIS_END,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_VIS_START = DEF_V_VIS_START,
    parameter int V_VIS_END   = DEF_V_VIS_END
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright
`ifdef FRAME_COUNT_EN
    ,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
`endif
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYN_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYN_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VS_C  = CNT_W'(H_VIS_START);
    localparam logic [CNT_W-1:0] H_VE_C  = CNT_W'(H_VIS_END);
    localparam logic [CNT_W-1:0] V_VS_C  = CNT_W'(V_VIS_START);
    localparam logic [CNT_W-1:0] V_VE_C  = CNT_W'(V_VIS_END);

    logic             pix_en_s;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             frame_wrap_s;
    logic             hsync_r;
    logic             vsync_r;
    logic             bright_r;

    clk_div_en #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div_en (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en_s)
    );

    // Next raster position; holds between strobes, wraps line then frame.
    always_comb begin
        h_next_s     = h_cnt_r;
        v_next_s     = v_cnt_r;
        frame_wrap_s = 1'b0;
        if (pix_en_s) begin
            if (h_cnt_r == H_LAST) begin
                h_next_s = 10'd0;
                if (v_cnt_r == V_LAST) begin
                    v_next_s     = 10'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    v_next_s = v_cnt_r + 10'd1;
                end
            end else begin
                h_next_s = h_cnt_r + 10'd1;
            end
        end else begin
            h_next_s = h_cnt_r;
            v_next_s = v_cnt_r;
        end
    end

    // Counters and decodes registered together from the next position.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_r  <= 10'd0;
            v_cnt_r  <= 10'd0;
            hsync_r  <= 1'b0;
            vsync_r  <= 1'b0;
            bright_r <= 1'b0;
        end else begin
            h_cnt_r  <= h_next_s;
            v_cnt_r  <= v_next_s;
            hsync_r  <= (h_next_s >= H_SYN_C);
            vsync_r  <= (v_next_s >= V_SYN_C);
            bright_r <= (h_next_s >= H_VS_C) && (h_next_s <= H_VE_C) &&
                        (v_next_s >= V_VS_C) && (v_next_s <= V_VE_C);
        end
    end

`ifdef FRAME_COUNT_EN
    logic        frame_start_r;
    logic [15:0] frame_cnt_r;

    // Frame pulse and counter step on the edge the raster returns to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
        end else begin
            frame_start_r <= frame_wrap_s;
            if (frame_wrap_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign frame_start = frame_start_r;
    assign frame_cnt   = frame_cnt_r;
`endif

    assign pix_en = pix_en_s;
    assign hCount = h_cnt_r;
    assign vCount = v_cnt_r;
    assign hSync  = hsync_r;
    assign vSync  = vsync_r;
    assign bright = bright_r;

endmodule
